// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with programmable almost-full/empty levels, occupancy count and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; otherwise r_data is registered.
module sync_fifo_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 6,
    parameter int AF_LEVEL  = 60,
    parameter int AE_LEVEL  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 w_en,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = DEPTH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AF_C    = AF_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AE_C    = AE_LEVEL[ADDR_SIZE:0];

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE:0]   wptr;
    logic [ADDR_SIZE:0]   rptr;
    logic [ADDR_SIZE:0]   count_nxt;
    logic                 wr_ok;
    logic                 rd_ok;

    // Flags decode the registered count, so acceptance always sees pre-edge state.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_ok = w_en & ~full & ~clr;
    assign rd_ok = r_en & ~empty & ~clr;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ADDR_SIZE-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            count <= count_nxt;
            if (w_en && full)  overflow  <= 1'b1;
            if (r_en && empty) underflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign r_data = mem[rptr[ADDR_SIZE-1:0]];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (rd_ok) begin
            r_data <= mem[rptr[ADDR_SIZE-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed plus randomized bench for sync_fifo_ctrl, checked against a queue-based reference model.
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          w_en = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          r_en = 1'b0;
    logic [DW-1:0] r_data;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    sync_fifo_ctrl #(
        .DATA_SIZE(DW),
        .ADDR_SIZE(AW),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .w_en        (w_en),
        .w_data      (w_data),
        .r_en        (r_en),
        .r_data      (r_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int sz;
        sz = q.size();
        chk({ctx, ":count"}, 32'(count), 32'(sz));
        chk({ctx, ":empty"}, 32'(empty), 32'(sz == 0));
        chk({ctx, ":full"}, 32'(full), 32'(sz == DEPTH));
        chk({ctx, ":almost_full"}, 32'(almost_full), 32'(sz >= AFL));
        chk({ctx, ":almost_empty"}, 32'(almost_empty), 32'(sz <= AEL));
        chk({ctx, ":overflow"}, 32'(overflow), 32'(m_ovf));
        chk({ctx, ":underflow"}, 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (sz > 0) chk({ctx, ":r_data"}, 32'(r_data), 32'(q[0]));
`else
        chk({ctx, ":r_data"}, 32'(r_data), 32'(m_rdata));
`endif
    endtask

    // One clock: drive inputs, model the edge from pre-edge occupancy, check at the next falling edge.
    task automatic step(input logic w, input logic [DW-1:0] wd, input logic r, input logic c,
                        input string ctx);
        int sz;
        w_en = w; w_data = wd; r_en = r; clr = c;
        @(posedge clk);
        sz = q.size();
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && sz == DEPTH) m_ovf = 1'b1;
            if (r && sz == 0)     m_udf = 1'b1;
            if (r && sz > 0)      m_rdata = q.pop_front();
            if (w && sz < DEPTH)  q.push_back(wd);
        end
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
        check_all(ctx);
    endtask

    initial begin
        logic [DW-1:0] basic_d[4];
        basic_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        // Reset state while rst_n is held low
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // Basic: four writes then four reads
        for (int i = 0; i < 4; i++) step(1'b1, basic_d[i], 1'b0, 1'b0, "basic_wr");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "basic_rd");
`ifndef SYNC_FIFO_FWFT_EN
            chk("basic_rd_value", 32'(r_data), 32'(basic_d[i]));
`endif
        end

        // Fill to full, then one write too many
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "overfill");

        // Full plus simultaneous read/write: read wins, write rejected
        step(1'b1, 8'hEF, 1'b1, 1'b0, "full_rw");
`ifndef SYNC_FIFO_FWFT_EN
        chk("full_rw_oldest", 32'(r_data), 32'h10);
`endif
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");

        // Empty plus simultaneous read/write: write wins, read rejected
        step(1'b1, 8'h5A, 1'b1, 1'b0, "empty_rw");
`ifdef SYNC_FIFO_FWFT_EN
        chk("empty_rw_present", 32'(r_data), 32'h5A);
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0, "empty_rw_rd");
`ifndef SYNC_FIFO_FWFT_EN
        chk("empty_rw_value", 32'(r_data), 32'h5A);
`endif

        // Randomized interleaving, long enough to wrap the pointers several times
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        // Flush with a simultaneous write
        while (q.size() > 9) step(1'b0, 8'h00, 1'b1, 1'b0, "to9_rd");
        while (q.size() < 9) step(1'b1, 8'($urandom), 1'b0, 1'b0, "to9_wr");
        step(1'b1, 8'h77, 1'b1, 1'b0, "pre_clr");
        step(1'b1, 8'h33, 1'b0, 1'b1, "clr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "after_clr_rd");

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "burst");
        w_en = 1'b1; w_data = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rdata = '0;
        check_all("async_reset");
        w_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hC7, 1'b0, 1'b0, "post_rst_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
